// File: rtl/tanh_backward.sv
// rtl/tanh_backward.sv - tanh backward pass: buffers forward activations, emits g*(1-y^2)
// Two-stage pipeline behind a FIFO of activations; pops pair the head activation with g.
module tanh_backward #(
   parameter int WIDTH = 32,
   parameter int FL    = 24,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     y_valid,
   input  logic [WIDTH-1:0]         y_in,
   output logic                     y_ready,
   input  logic                     g_valid,
   input  logic [WIDTH-1:0]         g_in,
   output logic                     g_ready,
   output logic                     d_valid,
   output logic [WIDTH-1:0]         d_out,
   input  logic                     d_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = 2 * WIDTH;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic signed [WIDTH:0] ONE_X = {{(WIDTH-FL){1'b0}}, 1'b1, {FL{1'b0}}};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             s1_v_q, s1_v_d;
   logic [WIDTH-1:0] s1_g_q, s1_g_d, s1_om_q, s1_om_d;
   logic             d_valid_q, d_valid_d;
   logic [WIDTH-1:0] d_out_q, d_out_d;

   logic advance, push, pop;
   logic signed [PW-1:0]    y_x, ysq_p, g_x, om_xx, gom_p;
   logic signed [WIDTH-1:0] sq;
   logic signed [WIDTH:0]   om_x;
   logic [WIDTH-1:0]        om, d_sat;
   logic [PW-FL-WIDTH:0]    p_top;
   logic                    ovf;
   logic                    unused_bits;

   assign advance = en && (!d_valid_q || d_ready);
   assign y_ready = en && (count_q < FULL);
   assign g_ready = advance && (count_q != '0);
   assign push    = y_valid && y_ready;
   assign pop     = g_valid && g_ready;

   // Stage 1: om = 1 - y^2 from the FIFO head, clamped to [0, 1.0]
   always_comb begin
      y_x   = PW'($signed(mem_q[rptr_q]));
      ysq_p = y_x * y_x;
      sq    = ysq_p[FL+WIDTH-1:FL];
      om_x  = ONE_X - {sq[WIDTH-1], sq};
      if (om_x[WIDTH])
         om = '0;
      else if (om_x > ONE_X)
         om = ONE_X[WIDTH-1:0];
      else
         om = om_x[WIDTH-1:0];
   end

   // Stage 2: g*om, saturated when the dropped high bits are not a sign extension
   always_comb begin
      g_x   = PW'($signed(s1_g_q));
      om_xx = {{WIDTH{1'b0}}, s1_om_q};
      gom_p = g_x * om_xx;
      p_top = gom_p[PW-1:FL+WIDTH-1];
      ovf   = !((&p_top) || !(|p_top));
      if (ovf)
         d_sat = gom_p[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
         d_sat = gom_p[FL+WIDTH-1:FL];
   end

   assign unused_bits = ^{ysq_p[PW-1:FL+WIDTH], ysq_p[FL-1:0], gom_p[FL-1:0]};

   always_comb begin
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      s1_v_d    = s1_v_q;
      s1_g_d    = s1_g_q;
      s1_om_d   = s1_om_q;
      d_valid_d = d_valid_q;
      d_out_d   = d_out_q;
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push)
         count_d = count_q - 1'b1;
      if (advance) begin
         s1_v_d    = pop;
         d_valid_d = s1_v_q;
         if (pop) begin
            s1_g_d  = g_in;
            s1_om_d = om;
         end
         if (s1_v_q) d_out_d = d_sat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         s1_v_q    <= 1'b0;
         s1_g_q    <= '0;
         s1_om_q   <= '0;
         d_valid_q <= 1'b0;
         d_out_q   <= '0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         s1_v_q    <= s1_v_d;
         s1_g_q    <= s1_g_d;
         s1_om_q   <= s1_om_d;
         d_valid_q <= d_valid_d;
         d_out_q   <= d_out_d;
      end
   end

   // Buffer storage is never reset; count gates every read of it
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= y_in;
   end

   assign d_valid = d_valid_q;
   assign d_out   = d_out_q;
   assign count   = count_q;

endmodule

// File: tb/tb_tanh_backward.sv
// tb/tb_tanh_backward.sv - randomized scoreboard bench for tanh_backward
// Reference model: activation queue plus plain integer arithmetic for g*(1-y^2).
module tb_tanh_backward;

   localparam longint ONE_L = 64'sd16777216;
   localparam longint MAXV  = 64'sh7FFFFFFF;
   localparam longint MINV  = -64'sh80000000;

   logic        clk = 1'b0;
   logic        rst, en, y_valid, g_valid, d_ready;
   logic [31:0] y_in, g_in;
   logic        y_ready, g_ready, d_valid;
   logic [31:0] d_out;
   logic [3:0]  count;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          yq[$];
   logic [31:0] exp_q[$];
   bit          last_acc_g;
   bit          hold_f = 1'b0;
   logic [31:0] hold_v;
   int          gs[3];

   tanh_backward #(.WIDTH(32), .FL(24), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .en(en),
      .y_valid(y_valid), .y_in(y_in), .y_ready(y_ready),
      .g_valid(g_valid), .g_in(g_in), .g_ready(g_ready),
      .d_valid(d_valid), .d_out(d_out), .d_ready(d_ready),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_d(input int y, input int g);
      longint sq, om, p;
      sq = (longint'(y) * longint'(y)) >>> 24;
      om = ONE_L - sq;
      if (om < 0) om = 0;
      if (om > ONE_L) om = ONE_L;
      p = (longint'(g) * om) >>> 24;
      if (p > MAXV) p = MAXV;
      if (p < MINV) p = MINV;
      return p[31:0];
   endfunction

   // One clock of stimulus; acceptance is predicted from the model where possible
   task automatic cycle(input bit yv, input int yd, input bit gv, input int gd);
      bit acc_y;
      y_valid = yv; y_in = yd; g_valid = gv; g_in = gd;
      @(negedge clk);
      check("count", 64'(count), 64'(yq.size()));
      acc_y = en && (yq.size() < 8);
      check("y_ready", 64'(y_ready), 64'(acc_y));
      if (!en || yq.size() == 0) check("g_ready_blocked", 64'(g_ready), 64'd0);
      if (d_valid && !d_ready) check("g_ready_stall", 64'(g_ready), 64'd0);
      last_acc_g = gv && g_ready;
      if (last_acc_g && yq.size() > 0) exp_q.push_back(ref_d(yq.pop_front(), gd));
      if (yv && acc_y) yq.push_back(yd);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 0);
   endtask

   function automatic int rand_y();
      return int'($urandom_range(0, 33554432)) - 16777216;
   endfunction

   // Monitor: consume results, check ordering and stability under backpressure
   always @(negedge clk) begin
      if (rst) begin
         hold_f = 1'b0;
      end else begin
         if (hold_f) begin
            check("hold_valid", 64'(d_valid), 64'd1);
            check("hold_data", 64'(d_out), 64'(hold_v));
         end
         hold_f = d_valid && (!d_ready || !en);
         hold_v = d_out;
         if (d_valid && d_ready && en) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_result: got %0h, want no result", d_out);
            end else begin
               check("d_out", 64'(d_out), 64'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time exceeded, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b1; y_valid = 1'b0; g_valid = 1'b0; d_ready = 1'b1;
      y_in = '0; g_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", 64'(count), 64'd0);
      check("rst_d_valid", 64'(d_valid), 64'd0);
      check("rst_d_out", 64'(d_out), 64'd0);
      check("rst_g_ready", 64'(g_ready), 64'd0);
      rst = 1'b0;

      // Basic value and two-cycle latency
      cycle(1'b1, 32'h00800000, 1'b0, 0);
      cycle(1'b0, 0, 1'b1, 32'h01000000);
      check("lat_pop_plus1", 64'(d_valid), 64'd0);
      cycle(1'b0, 0, 1'b0, 0);
      check("lat_pop_plus2", 64'(d_valid), 64'd1);
      check("basic_value", 64'(d_out), 64'h00C00000);
      idle(3);

      // Saturated and zero activation
      cycle(1'b1, 32'hFF000000, 1'b0, 0);
      cycle(1'b1, 32'h00000000, 1'b1, 32'h02000000);
      cycle(1'b0, 0, 1'b1, 32'hFC800000);
      idle(4);

      // Fill to full, refused ninth push, drain in order
      for (int i = 0; i < 8; i++) cycle(1'b1, 32'h00100000 * i - 32'h00300000, 1'b0, 0);
      check("full_count", 64'(count), 64'd8);
      check("full_y_ready", 64'(y_ready), 64'd0);
      cycle(1'b1, 32'h00700000, 1'b0, 0);
      for (int i = 0; i < 8; i++) cycle(1'b0, 0, 1'b1, 32'h01000000 + 32'h00110000 * i);
      idle(3);
      check("empty_count", 64'(count), 64'd0);
      cycle(1'b0, 0, 1'b1, 32'h01234567);
      idle(2);

      // Backpressure: d_ready low for 5 cycles during a 3-result burst
      for (int i = 0; i < 3; i++) cycle(1'b1, rand_y(), 1'b0, 0);
      gs[0] = 32'h00A00000; gs[1] = 32'hFF300000; gs[2] = 32'h03000000;
      begin
         int idx = 0;
         for (int c = 0; c < 40; c++) begin
            d_ready = !(c >= 1 && c < 6);
            if (idx < 3) begin
               cycle(1'b0, 0, 1'b1, gs[idx]);
               if (last_acc_g) idx++;
            end else begin
               cycle(1'b0, 0, 1'b0, 0);
            end
         end
         check("bp_all_popped", 64'(idx), 64'd3);
      end
      d_ready = 1'b1;
      idle(3);

      // Simultaneous push/pop at count 4, then 20 wrapping pairs
      for (int i = 0; i < 4; i++) cycle(1'b1, rand_y(), 1'b0, 0);
      cycle(1'b1, rand_y(), 1'b1, int'($urandom()));
      check("simul_count", 64'(count), 64'd4);
      for (int i = 0; i < 20; i++) cycle(1'b1, rand_y(), 1'b1, int'($urandom()));
      check("wrap_count", 64'(count), 64'd4);
      for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1, int'($urandom()));
      idle(3);

      // Random traffic with random enable and backpressure
      for (int i = 0; i < 400; i++) begin
         en      = ($urandom_range(0, 7) != 0);
         d_ready = ($urandom_range(0, 3) != 0);
         cycle($urandom_range(0, 1) == 1, rand_y(), $urandom_range(0, 1) == 1, int'($urandom()));
      end
      en = 1'b1; d_ready = 1'b1;
      for (int i = 0; i < 10; i++) cycle(1'b0, 0, 1'b1, int'($urandom()));
      idle(3);

      // Asynchronous reset while count=3 and a result is pending
      for (int i = 0; i < 5; i++) cycle(1'b1, rand_y(), 1'b0, 0);
      d_ready = 1'b0;
      cycle(1'b0, 0, 1'b1, int'($urandom()));
      cycle(1'b0, 0, 1'b1, int'($urandom()));
      g_valid = 1'b0;
      check("pre_rst_count", 64'(count), 64'd3);
      check("pre_rst_valid", 64'(d_valid), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_count", 64'(count), 64'd0);
      check("arst_d_valid", 64'(d_valid), 64'd0);
      check("arst_d_out", 64'(d_out), 64'd0);
      yq.delete();
      exp_q.delete();
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      d_ready = 1'b1;
      cycle(1'b1, 32'h00800000, 1'b0, 0);
      cycle(1'b0, 0, 1'b1, 32'h01000000);
      cycle(1'b0, 0, 1'b0, 0);
      check("post_rst_value", 64'(d_out), 64'h00C00000);

      y_valid = 1'b0; g_valid = 1'b0; d_ready = 1'b1;
      for (int i = 0; i < 50 && exp_q.size() > 0; i++) begin
         @(posedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d outstanding, want 0", exp_q.size());
      end
      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
